// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// load/store type bit positions, bus size codes, FSM states and request payload.
package mem_access_ctrl_pkg;

  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_BYTES  = MEM_DATA_W / 8;
  localparam int unsigned LS_W       = 8;
  localparam int unsigned LD_W       = 5;

  localparam int unsigned LS_LB  = 0;
  localparam int unsigned LS_LBU = 1;
  localparam int unsigned LS_LH  = 2;
  localparam int unsigned LS_LHU = 3;
  localparam int unsigned LS_LW  = 4;
  localparam int unsigned LS_SB  = 5;
  localparam int unsigned LS_SH  = 6;
  localparam int unsigned LS_SW  = 7;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bus request fields plus the load kind needed to extend the returned data
  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_BYTES-1:0]  wstrb;
    logic [LD_W-1:0]       ld_type;
  } req_t;

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Load data formatter: picks the byte/half lane from the raw bus word and
// sign- or zero-extends it according to the load kind.
module mem_access_ctrl_load_ext
  import mem_access_ctrl_pkg::*;
(
  input  logic [MEM_DATA_W-1:0] rdata_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [LD_W-1:0]       ld_type_i,
  output logic [MEM_DATA_W-1:0] ext_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ext_o = '0;
    if (ld_type_i[LS_LB])       ext_o = {{24{byte_v[7]}}, byte_v};
    else if (ld_type_i[LS_LBU]) ext_o = {24'h0, byte_v};
    else if (ld_type_i[LS_LH])  ext_o = {{16{half_v[15]}}, half_v};
    else if (ld_type_i[LS_LHU]) ext_o = {16'h0, half_v};
    else if (ld_type_i[LS_LW])  ext_o = rdata_i;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: alignment checks, store formatting,
// SRAM-like req/addr_ok/data_ok handshake, load extension and pipeline stall.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LS_W-1:0]   l_s_typeM,
  input  logic [ADDR_W-1:0] mem_addrM,
  input  logic [DATA_W-1:0] rt_valueM,
  input  logic              excepM,
  input  logic              flushM,
  input  logic              stall_ext,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] mem_rdataM,
  output logic              stall_mem,
  output logic              adelM,
  output logic              adesM,
  output logic [ADDR_W-1:0] bad_vaddrM
);

  state_e                state_q, state_d;
  req_t                  req_q, req_d, req_live;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     held_q, held_d;
  logic                  cancel_q, cancel_d;
  logic [MEM_DATA_W-1:0] ext_data;

  logic is_load, is_store, is_half, is_word, misaligned, need_access;

  assign is_load     = |l_s_typeM[LS_LW:LS_LB];
  assign is_store    = |l_s_typeM[LS_SW:LS_SB];
  assign is_half     = l_s_typeM[LS_LH] | l_s_typeM[LS_LHU] | l_s_typeM[LS_SH];
  assign is_word     = l_s_typeM[LS_LW] | l_s_typeM[LS_SW];
  assign misaligned  = (is_half & mem_addrM[0]) | (is_word & (mem_addrM[1:0] != 2'b00));
  assign need_access = (is_load | is_store) & ~misaligned & ~excepM & ~flushM;

  assign adelM      = is_load & misaligned;
  assign adesM      = is_store & misaligned;
  assign bad_vaddrM = misaligned ? mem_addrM : '0;

  // Request as it would be issued from the live M-stage inputs
  always_comb begin
    req_live         = '0;
    req_live.wr      = is_store;
    req_live.ld_type = l_s_typeM[LS_LW:LS_LB];
    req_live.size    = is_word ? SIZE_W : (is_half ? SIZE_H : SIZE_B);
    if (l_s_typeM[LS_SB]) begin
      req_live.wdata = {4{rt_valueM[7:0]}};
      req_live.wstrb = 4'b0001 << mem_addrM[1:0];
    end else if (l_s_typeM[LS_SH]) begin
      req_live.wdata = {2{rt_valueM[15:0]}};
      req_live.wstrb = mem_addrM[1] ? 4'b1100 : 4'b0011;
    end else if (l_s_typeM[LS_SW]) begin
      req_live.wdata = rt_valueM;
      req_live.wstrb = 4'b1111;
    end
  end

  mem_access_ctrl_load_ext u_load_ext (
    .rdata_i   (data_rdata),
    .addr_lo_i (addr_q[1:0]),
    .ld_type_i (req_q.ld_type),
    .ext_o     (ext_data)
  );

  // Next-state logic; a cancelled access still runs its handshake to completion
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    held_d   = held_q;
    cancel_d = cancel_q;
    case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        if (need_access) begin
          req_d   = req_live;
          addr_d  = mem_addrM;
          state_d = data_addr_ok ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (flushM)       cancel_d = 1'b1;
        if (data_addr_ok) state_d  = ST_DATA;
      end
      ST_DATA: begin
        if (flushM) cancel_d = 1'b1;
        if (data_data_ok) begin
          if (stall_ext && !cancel_q && !flushM) begin
            held_d  = ext_data;
            state_d = ST_DONE;
          end else begin
            cancel_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        if (!stall_ext) state_d = ST_IDLE;
      end
    endcase
  end

  // Bus, result and stall outputs; ADDR/DATA use the captured request
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = SIZE_B;
    data_addr  = '0;
    data_wdata = '0;
    data_wstrb = '0;
    mem_rdataM = '0;
    stall_mem  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        data_req  = need_access;
        stall_mem = need_access;
        if (need_access) begin
          data_wr    = req_live.wr;
          data_size  = req_live.size;
          data_addr  = mem_addrM;
          data_wdata = req_live.wdata;
          data_wstrb = req_live.wstrb;
        end
      end
      ST_ADDR: begin
        data_req   = 1'b1;
        data_wr    = req_q.wr;
        data_size  = req_q.size;
        data_addr  = addr_q;
        data_wdata = req_q.wdata;
        data_wstrb = req_q.wstrb;
        stall_mem  = ~cancel_q;
      end
      ST_DATA: begin
        stall_mem = ~cancel_q & ~data_data_ok;
        if (data_data_ok && !cancel_q) mem_rdataM = ext_data;
      end
      default: begin
        mem_rdataM = held_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      addr_q   <= '0;
      held_q   <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      held_q   <= held_d;
      cancel_q <= cancel_d;
    end
  end

endmodule
